// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit op codes, issuer FSM states, MIPS opcode/funct constants.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_SLT = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_BEQ = 4'b0111,
    ALU_LUI = 4'b1000,
    ALU_BGT = 4'b1001,
    ALU_BNE = 4'b1010,
    ALU_MUL = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } iss_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Compare ops report only the zero flag; their numeric result is dropped.
  function automatic logic is_cmp_op(input alu_op_e op);
    return (op == ALU_BEQ) || (op == ALU_BGT) || (op == ALU_BNE);
  endfunction

endpackage

// File: rtl/alu_issuer_dec.sv
// Combinational MIPS decoder for alu_issuer.
// Multiply (funct 0x18) decodes only when ALU_ISSUER_MUL_EN is defined.
module alu_issuer_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output alu_op_e     ctrl_o,
  output logic        src2_imm_o,
  output logic [31:0] imm_o,
  output logic [31:0] shamt_o,
  output logic        illegal_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign imm_o         = {{16{instr_i[15]}}, instr_i[15:0]};
  assign unused_fields = ^instr_i[25:16];

  // Opcode/funct to ALU op, operand-2 source and shift amount.
  always_comb begin
    ctrl_o     = ALU_AND;
    src2_imm_o = 1'b0;
    shamt_o    = '0;
    illegal_o  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_AND: ctrl_o = ALU_AND;
          FN_OR:  ctrl_o = ALU_OR;
          FN_ADD: ctrl_o = ALU_ADD;
          FN_SUB: ctrl_o = ALU_SUB;
          FN_SLT: ctrl_o = ALU_SLT;
          FN_SRL: ctrl_o = ALU_SRL;
          FN_SLL: begin
            ctrl_o  = ALU_SLL;
            shamt_o = {27'b0, instr_i[10:6]};
          end
`ifdef ALU_ISSUER_MUL_EN
          FN_MUL: ctrl_o = ALU_MUL;
`endif
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI: begin ctrl_o = ALU_ADD; src2_imm_o = 1'b1; end
      OP_SLTI: begin ctrl_o = ALU_SLT; src2_imm_o = 1'b1; end
      OP_LUI:  begin ctrl_o = ALU_LUI; src2_imm_o = 1'b1; end
      OP_BEQ:  ctrl_o = ALU_BEQ;
      OP_BNE:  ctrl_o = ALU_BNE;
      OP_BGT:  ctrl_o = ALU_BGT;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: accepts one MIPS instruction, drives registered ALU operands,
// waits out EXEC, captures the ALU result and holds it until consumed.
// Optional multiply support under macro ALU_ISSUER_MUL_EN.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int          MUL_WAIT   = 2,
  parameter logic [31:0] ERR_RESULT = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_instr_i,
  input  logic [31:0] cmd_rs_i,
  input  logic [31:0] cmd_rt_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [31:0] alu_shamt_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_flag_o,
  output logic        rsp_err_o
);

  alu_op_e     dec_ctrl;
  logic        dec_src2_imm;
  logic [31:0] dec_imm;
  logic [31:0] dec_shamt;
  logic        dec_illegal;

  alu_issuer_dec u_dec (
    .instr_i    (cmd_instr_i),
    .ctrl_o     (dec_ctrl),
    .src2_imm_o (dec_src2_imm),
    .imm_o      (dec_imm),
    .shamt_o    (dec_shamt),
    .illegal_o  (dec_illegal)
  );

  iss_state_e  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] src2_q, src2_d;
  logic [31:0] shamt_q, shamt_d;
  alu_op_e     ctrl_q, ctrl_d;
  logic [31:0] result_q, result_d;
  logic        flag_q, flag_d;
  logic        err_q, err_d;
  logic        exec_done;
`ifdef ALU_ISSUER_MUL_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  // Next-state and response capture for the IDLE -> EXEC -> RESP handshake.
  always_comb begin
    state_d   = state_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    shamt_d   = shamt_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
    flag_d    = flag_q;
    err_d     = err_q;
    exec_done = 1'b1;
`ifdef ALU_ISSUER_MUL_EN
    cnt_d     = cnt_q;
    exec_done = (cnt_q == 4'd0);
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (dec_illegal) begin
            // Illegal instructions skip the ALU entirely.
            state_d  = ST_RESP;
            result_d = ERR_RESULT;
            flag_d   = 1'b0;
            err_d    = 1'b1;
          end else begin
            state_d = ST_EXEC;
            src1_d  = cmd_rs_i;
            src2_d  = dec_src2_imm ? dec_imm : cmd_rt_i;
            shamt_d = dec_shamt;
            ctrl_d  = dec_ctrl;
`ifdef ALU_ISSUER_MUL_EN
            cnt_d   = (dec_ctrl == ALU_MUL) ? 4'(MUL_WAIT) : 4'd0;
`endif
          end
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          state_d  = ST_RESP;
          err_d    = 1'b0;
          flag_d   = is_cmp_op(ctrl_q) ? alu_zero_i : 1'b0;
          result_d = is_cmp_op(ctrl_q) ? 32'd0 : alu_result_i;
        end
`ifdef ALU_ISSUER_MUL_EN
        else begin
          cnt_d = cnt_q - 4'd1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and registered outputs; reset drops any in-flight operation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      shamt_q     <= '0;
      ctrl_q      <= ALU_AND;
      result_q    <= '0;
      flag_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_ISSUER_MUL_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      shamt_q     <= shamt_d;
      ctrl_q      <= ctrl_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      err_q       <= err_d;
`ifdef ALU_ISSUER_MUL_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign alu_src1_o   = src1_q;
  assign alu_src2_o   = src2_q;
  assign alu_ctrl_o   = ctrl_q;
  assign alu_shamt_o  = shamt_q;
  assign rsp_result_o = result_q;
  assign rsp_flag_o   = flag_q;
  assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed testbench for alu_issuer (checks multiply path when ALU_ISSUER_MUL_EN is defined).
module tb_alu_issuer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_instr_i = '0;
  logic [31:0] cmd_rs_i = '0;
  logic [31:0] cmd_rt_i = '0;
  logic [31:0] alu_src1_o, alu_src2_o, alu_shamt_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i = '0;
  logic        alu_zero_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  logic        rsp_flag_o, rsp_err_o;

  int n_chk = 0;
  int n_err = 0;

  alu_issuer #(.MUL_WAIT(2), .ERR_RESULT(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_instr_i(cmd_instr_i), .cmd_rs_i(cmd_rs_i), .cmd_rt_i(cmd_rt_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_shamt_o(alu_shamt_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_flag_o(rsp_flag_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one command for exactly one edge (DUT is expected to be in IDLE).
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    cmd_valid_i = 1'b1;
    cmd_instr_i = instr;
    cmd_rs_i    = rs;
    cmd_rt_i    = rt;
    step();
    cmd_valid_i = 1'b0;
  endtask

  // Consume the pending response and return to IDLE.
  task automatic drain();
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("drain_valid", 32'(rsp_valid_o), 32'd0);
    chk("drain_ready", 32'(cmd_ready_o), 32'd1);
  endtask

  // Single-cycle op: check EXEC outputs, feed ALU result, check response.
  task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [3:0] ctrl, input logic [31:0] src2,
                        input logic [31:0] shamt, input logic [31:0] alu_res, input logic zero,
                        input logic [31:0] exp_res, input logic exp_flag);
    issue(instr, rs, rt);
    chk({tag, "_ctrl"}, 32'(alu_ctrl_o), 32'(ctrl));
    chk({tag, "_src1"}, alu_src1_o, rs);
    chk({tag, "_src2"}, alu_src2_o, src2);
    chk({tag, "_shamt"}, alu_shamt_o, shamt);
    chk({tag, "_exec_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_exec_ready"}, 32'(cmd_ready_o), 32'd0);
    alu_result_i = alu_res;
    alu_zero_i   = zero;
    step();
    chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, "_result"}, rsp_result_o, exp_res);
    chk({tag, "_flag"}, 32'(rsp_flag_o), 32'(exp_flag));
    chk({tag, "_err"}, 32'(rsp_err_o), 32'd0);
    drain();
  endtask

  initial begin
    step();
    step();
    rst_i = 1'b0;
    step();
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    chk("rst_flag", 32'(rsp_flag_o), 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
    chk("rst_src1", alu_src1_o, 32'd0);
    chk("rst_src2", alu_src2_o, 32'd0);
    chk("rst_shamt", alu_shamt_o, 32'd0);
    chk("rst_result", rsp_result_o, 32'd0);

    // add $3,$1,$2 : 5+7
    run_op("add", 32'h0022_1820, 32'd5, 32'd7, 4'b0010, 32'd7, 32'd0, 32'd12, 1'b0, 32'd12, 1'b0);
    // beq taken, rs=rt=9; ALU result ignored for compares
    run_op("beq", 32'h1022_0010, 32'd9, 32'd9, 4'b0111, 32'd9, 32'd0, 32'h1234, 1'b1, 32'd0, 1'b1);
    // bne not taken
    run_op("bne", 32'h1422_0010, 32'd3, 32'd4, 4'b1010, 32'd4, 32'd0, 32'h55, 1'b0, 32'd0, 1'b0);
    // bgt
    run_op("bgt", 32'h1C22_0008, 32'd8, 32'd2, 4'b1001, 32'd2, 32'd0, 32'h1, 1'b1, 32'd0, 1'b1);
    // sll $2,$2,4 : src2 = rt
    run_op("sll", 32'h0002_1100, 32'h11, 32'h3, 4'b0101, 32'h3, 32'd4, 32'h30, 1'b0, 32'h30, 1'b0);
    // addi with negative immediate -4
    run_op("addi", 32'h2022_FFFC, 32'd10, 32'h77, 4'b0010, 32'hFFFF_FFFC, 32'd0, 32'd6, 1'b0, 32'd6, 1'b0);
    // lui, positive immediate 0x1234
    run_op("lui", 32'h3C02_1234, 32'd0, 32'h9, 4'b1000, 32'h0000_1234, 32'd0, 32'h1234_0000, 1'b0, 32'h1234_0000, 1'b0);
    // slt / srl / sub / or
    run_op("slt", 32'h0022_182A, 32'd1, 32'd2, 4'b0100, 32'd2, 32'd0, 32'd1, 1'b0, 32'd1, 1'b0);
    run_op("srl", 32'h0022_1806, 32'd1, 32'd2, 4'b0110, 32'd2, 32'd0, 32'd9, 1'b0, 32'd9, 1'b0);
    run_op("sub", 32'h0022_1822, 32'd9, 32'd2, 4'b0011, 32'd2, 32'd0, 32'd7, 1'b1, 32'd7, 1'b0);

    // Illegal opcode 0x3F with 5 cycles of backpressure
    issue(32'hFC00_0000, 32'd1, 32'd2);
    chk("ill_valid", 32'(rsp_valid_o), 32'd1);
    chk("ill_err", 32'(rsp_err_o), 32'd1);
    chk("ill_result", rsp_result_o, 32'hDEAD_BEEF);
    chk("ill_ctrl_kept", 32'(alu_ctrl_o), 32'b0011);
    for (int i = 0; i < 5; i++) begin
      cmd_valid_i = 1'b1;
      cmd_instr_i = 32'h0022_1824;
      step();
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_result", rsp_result_o, 32'hDEAD_BEEF);
      chk("bp_err", 32'(rsp_err_o), 32'd1);
      chk("bp_ready", 32'(cmd_ready_o), 32'd0);
    end
    // Handshake with cmd_valid still high: must not be taken on that edge
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b0;
    chk("hs_valid", 32'(rsp_valid_o), 32'd0);
    chk("hs_ready", 32'(cmd_ready_o), 32'd1);
    chk("hs_ctrl_kept", 32'(alu_ctrl_o), 32'b0011);

`ifdef ALU_ISSUER_MUL_EN
    // mul: response 4 cycles after accept
    issue(32'h0022_1818, 32'd6, 32'd7);
    chk("mul_ctrl", 32'(alu_ctrl_o), 32'b1011);
    alu_result_i = 32'd42;
    alu_zero_i   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mul_wait_valid", 32'(rsp_valid_o), 32'd0);
    end
    step();
    chk("mul_valid", 32'(rsp_valid_o), 32'd1);
    chk("mul_result", rsp_result_o, 32'd42);
    drain();
    // reset mid-EXEC on a multiply
    issue(32'h0022_1818, 32'd6, 32'd7);
    step();
`else
    // Without multiply support funct 0x18 is illegal
    issue(32'h0022_1818, 32'd6, 32'd7);
    chk("mul_ill_valid", 32'(rsp_valid_o), 32'd1);
    chk("mul_ill_err", 32'(rsp_err_o), 32'd1);
    chk("mul_ill_result", rsp_result_o, 32'hDEAD_BEEF);
    drain();
    // reset mid-EXEC on an add
    issue(32'h0022_1820, 32'd5, 32'd7);
`endif
    chk("mid_exec", 32'(rsp_valid_o), 32'd0);
    #1 rst_i = 1'b1;
    #2 rst_i = 1'b0;
    chk("rstx_ready", 32'(cmd_ready_o), 32'd1);
    chk("rstx_ctrl", 32'(alu_ctrl_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstx_no_rsp", 32'(rsp_valid_o), 32'd0);
      chk("rstx_ready_hold", 32'(cmd_ready_o), 32'd1);
    end

    // Still functional after the reset
    run_op("and", 32'h0022_1824, 32'hF0, 32'h3C, 4'b0000, 32'h3C, 32'd0, 32'h30, 1'b0, 32'h30, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 The block SHALL have parameter MUL_WAIT, default 2, giving extra EXEC cycles held for multiply (0..15).
REQ-002 The block SHALL have parameter ERR_RESULT, default 32'hDEAD_BEEF, giving the result returned for illegal instructions.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_instr_i  in  32  MIPS instruction word
- cmd_rs_i  in  32  rs register value
- cmd_rt_i  in  32  rt register value
- alu_src1_o  out  32  ALU operand 1
- alu_src2_o  out  32  ALU operand 2
- alu_ctrl_o  out  4  ALU operation code
- alu_shamt_o  out  32  shift amount, zero-extended
- alu_result_i  in  32  ALU result
- alu_zero_i  in  1  ALU compare flag
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_result_o  out  32  captured result
- rsp_flag_o  out  1  captured compare flag
- rsp_err_o  out  1  illegal instruction

Function
REQ-004 The block SHALL implement FSM states IDLE, EXEC, RESP; cmd_ready_o SHALL be high only in IDLE.
REQ-005 IDLE SHALL, on cmd_valid_i&cmd_ready_o, register decoded ALU outputs and enter EXEC, or enter RESP directly with rsp_err_o=1 and rsp_result_o=ERR_RESULT when illegal.
REQ-006 EXEC SHALL last 1 cycle, or 1+MUL_WAIT cycles for multiply (down-counter); on its last cycle alu_result_i and alu_zero_i SHALL be captured and RESP entered.
REQ-007 RESP SHALL hold rsp_valid_o high with stable response until rsp_ready_i, then return to IDLE; a new command SHALL not be accepted in that same cycle.
REQ-008 ALU outputs SHALL be registered and stable from EXEC entry until the next accepted command.
REQ-009 R-type (opcode 0) funct decode SHALL be: 0x24->0000, 0x25->0001, 0x20->0010, 0x22->0011, 0x2A->0100, 0x00->0101, 0x06->0110, 0x18->1011; src1=rs, src2=rt.
REQ-010 I-type decode SHALL be: 0x08 addi->0010, 0x0A slti->0100, 0x0F lui->1000, 0x04 beq->0111, 0x05 bne->1010, 0x07 bgt->1001; src1=rs, src2=sign-extended imm16 (beq/bne/bgt: src2=rt).
REQ-011 alu_shamt_o SHALL be {27'b0, instr[10:6]} for sll and 0 otherwise.
REQ-012 rsp_flag_o SHALL equal captured alu_zero_i for 0111/1001/1010 and 0 otherwise; rsp_result_o for these SHALL be 0.
REQ-013 Any other opcode/funct SHALL be illegal.

Reset
REQ-014 Reset SHALL force IDLE, cmd_ready_o=1 after release, rsp_valid_o=0, rsp_err_o=0, rsp_flag_o=0, all data outputs and alu_ctrl_o to 0, counter to 0.
REQ-015 Reset asserted in EXEC or RESP SHALL discard the operation; no response SHALL appear after release.

Configuration
REQ-016 With macro ALU_ISSUER_MUL_EN defined, funct 0x18 SHALL decode to 1011 with MUL_WAIT extra cycles; without it, 0x18 SHALL be illegal and the counter logic SHALL be absent.

Structure
REQ-017 The 4-bit ALU op codes, FSM state enum, opcode/funct constants SHALL reside in shared package alu_pkg, also used by ALU control.
REQ-018 Decoding SHALL be a combinational sub-module alu_issuer_dec (instr in; ctrl, operand selects, shamt, illegal out).

Verification
REQ-019 add: instr 0x00221820, rs=5, rt=7 -> alu_ctrl_o=0010 in EXEC, rsp_result_o=12, rsp_valid_o 2 cycles after accept.
REQ-020 beq taken: opcode 0x04, rs=rt=9, ALU zero=1 -> rsp_flag_o=1, rsp_result_o=0.
REQ-021 sll: instr 0x00021100 -> alu_shamt_o=4, ctrl 0101, src2=rt.
REQ-022 Illegal opcode 0x3F -> no EXEC, rsp_err_o=1, rsp_result_o=0xDEADBEEF one cycle after accept.
REQ-023 Backpressure: rsp_ready_i low 5 cycles -> response stable, cmd_ready_o low throughout; IDLE one cycle after handshake.
REQ-024 mul with ALU_ISSUER_MUL_EN, MUL_WAIT=2: response 4 cycles after accept; reset pulse mid-EXEC -> no response, cmd_ready_o=1.
